// File: rtl/fwd_sel_ctrl.sv
// Operand-forwarding select and load-use stall controller for the EX-stage ALU muxes.
// Define FWD_SEL_STATS_EN to add the saturating stall/forward statistics counters.
module fwd_sel_ctrl #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_imm_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall_id,
  output logic [2:0]            ex_sel_a,
  output logic [2:0]            ex_sel_b
`ifdef FWD_SEL_STATS_EN
  ,
  output logic [31:0]           stat_stalls,
  output logic [31:0]           stat_fwds
`endif
);

  localparam logic [2:0] SEL_RF  = 3'd0;
  localparam logic [2:0] SEL_IMM = 3'd4;

  // Scoreboard index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]            sb_valid;
  logic [2:0]            sb_we;
  logic [2:0]            sb_load;
  logic [REG_ADDR_W-1:0] sb_rd [3];

  logic [2:0] match_a;
  logic [2:0] match_b;
  logic [2:0] sel_a_next;
  logic [2:0] sel_b_next;
  logic       load_hit;
  logic       advance;

  function automatic logic src_match(input logic                  valid,
                                     input logic                  we,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic                  used);
    return valid && we && (rd == rs) && (rs != '0) && used;
  endfunction

  // Youngest producer wins; no producer means the register-file value is fresh.
  function automatic logic [2:0] pick_sel(input logic [2:0] m);
    if (m[0])      return 3'd1;
    else if (m[1]) return 3'd2;
    else if (m[2]) return 3'd3;
    else           return SEL_RF;
  endfunction

  always_comb begin
    match_a  = '0;
    match_b  = '0;
    load_hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      match_a[k] = src_match(sb_valid[k], sb_we[k], sb_rd[k], id_rs1, id_rs1_used);
      match_b[k] = src_match(sb_valid[k], sb_we[k], sb_rd[k], id_rs2, id_rs2_used) && !id_imm_b;
      if ((k < LOAD_STALL_CYCLES) && sb_load[k] && (match_a[k] || match_b[k]))
        load_hit = 1'b1;
    end
    sel_a_next = pick_sel(match_a);
    sel_b_next = id_imm_b ? SEL_IMM : pick_sel(match_b);
  end

  assign stall_id = id_valid && !flush && load_hit;
  assign advance  = id_valid && !stall_id && !flush;

  // Everything freezes under hold; otherwise the pipe shifts and ID enters EX or a bubble does.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_valid <= '0;
      sb_we    <= '0;
      sb_load  <= '0;
      for (int k = 0; k < 3; k++) sb_rd[k] <= '0;
      ex_sel_a <= SEL_RF;
      ex_sel_b <= SEL_RF;
    end else if (!hold) begin
      sb_valid[2] <= sb_valid[1];
      sb_we[2]    <= sb_we[1];
      sb_load[2]  <= sb_load[1];
      sb_rd[2]    <= sb_rd[1];
      sb_valid[1] <= sb_valid[0];
      sb_we[1]    <= sb_we[0];
      sb_load[1]  <= sb_load[0];
      sb_rd[1]    <= sb_rd[0];
      if (advance) begin
        sb_valid[0] <= 1'b1;
        sb_we[0]    <= id_regwrite;
        sb_load[0]  <= id_is_load;
        sb_rd[0]    <= id_rd;
        ex_sel_a    <= sel_a_next;
        ex_sel_b    <= sel_b_next;
      end else begin
        sb_valid[0] <= 1'b0;
        sb_we[0]    <= 1'b0;
        sb_load[0]  <= 1'b0;
        sb_rd[0]    <= '0;
        ex_sel_a    <= SEL_RF;
        ex_sel_b    <= SEL_RF;
      end
    end
  end

`ifdef FWD_SEL_STATS_EN
  logic fwd_hit;

  assign fwd_hit = (sel_a_next != SEL_RF) ||
                   ((sel_b_next != SEL_RF) && (sel_b_next != SEL_IMM));

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_stalls <= '0;
      stat_fwds   <= '0;
    end else if (!hold) begin
      if (stall_id && (stat_stalls != 32'hFFFF_FFFF))
        stat_stalls <= stat_stalls + 32'd1;
      if (advance && fwd_hit && (stat_fwds != 32'hFFFF_FFFF))
        stat_fwds <= stat_fwds + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: one instance with a 1-cycle load penalty, one with 2.
module tb_fwd_sel_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic       id_valid2;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       id_imm_b;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       hold;
  logic       flush;
  logic       stall_id;
  logic [2:0] ex_sel_a;
  logic [2:0] ex_sel_b;
  logic       stall_id2;
  logic [2:0] ex_sel_a2;
  logic [2:0] ex_sel_b2;

  int  errors = 0;
  int  checks = 0;
  // Routes id_valid to the second instance instead of the first.
  logic target2 = 1'b0;

  always #5 clk = ~clk;

  fwd_sel_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_imm_b(id_imm_b), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .hold(hold), .flush(flush), .stall_id(stall_id), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b)
  );

  fwd_sel_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_imm_b(id_imm_b), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .hold(hold), .flush(flush), .stall_id(stall_id2), .ex_sel_a(ex_sel_a2), .ex_sel_b(ex_sel_b2)
  );

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic immb,
                               input logic [4:0] rd, input logic rw, input logic ld);
    id_valid    = target2 ? 1'b0 : v;
    id_valid2   = target2 ? v : 1'b0;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_imm_b    = immb;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Plain ALU op: reads rs1/rs2, writes rd.
  task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    applyStimulus(1'b1, rs1, rs2, 1'b1, 1'b1, 1'b0, rd, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [4:0] rs1, input logic [4:0] rd);
    applyStimulus(1'b1, rs1, 5'd0, 1'b1, 1'b0, 1'b0, rd, 1'b1, 1'b1);
  endtask

  task automatic nop();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    nop();
    #2;
    checkOutput("reset_stall", stall_id, 0);
    checkOutput("reset_sel_a", ex_sel_a, 0);
    checkOutput("reset_sel_b", ex_sel_b, 0);
    #1 reset_n = 1'b1;
    cycle();

    // Back-to-back dependency
    alu(5'd1, 5'd2, 5'd5);
    #1 checkOutput("b2b_prod_stall", stall_id, 0);
    cycle();
    alu(5'd5, 5'd6, 5'd6);
    #1 checkOutput("b2b_cons_stall", stall_id, 0);
    cycle();
    checkOutput("b2b_sel_a", ex_sel_a, 1);
    checkOutput("b2b_sel_b", ex_sel_b, 0);

    // Distance 2
    alu(5'd1, 5'd2, 5'd7);  cycle();
    alu(5'd1, 5'd2, 5'd11); cycle();
    applyStimulus(1'b1, 5'd8, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 checkOutput("dist2_stall", stall_id, 0);
    cycle();
    checkOutput("dist2_sel_b", ex_sel_b, 2);
    checkOutput("dist2_sel_a", ex_sel_a, 0);

    // Distance 3
    alu(5'd1, 5'd2, 5'd7);  cycle();
    alu(5'd1, 5'd2, 5'd11); cycle();
    alu(5'd1, 5'd2, 5'd12); cycle();
    applyStimulus(1'b1, 5'd8, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle();
    checkOutput("dist3_sel_b", ex_sel_b, 3);

    // Load-use with a 1-cycle penalty
    load(5'd1, 5'd3);
    cycle();
    alu(5'd3, 5'd4, 5'd14);
    #1 checkOutput("lu1_stall_first", stall_id, 1);
    cycle();
    checkOutput("lu1_bubble_sel_a", ex_sel_a, 0);
    checkOutput("lu1_bubble_sel_b", ex_sel_b, 0);
    #1 checkOutput("lu1_stall_second", stall_id, 0);
    cycle();
    checkOutput("lu1_sel_a", ex_sel_a, 2);

    // x0 producer and immediate operand B
    alu(5'd1, 5'd2, 5'd0); cycle();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
    #1 checkOutput("x0_stall", stall_id, 0);
    cycle();
    checkOutput("x0_sel_a", ex_sel_a, 0);
    checkOutput("imm_sel_b", ex_sel_b, 4);

    // Priority: x9 in S1 and S3
    alu(5'd1, 5'd2, 5'd9);  cycle();
    alu(5'd1, 5'd2, 5'd13); cycle();
    alu(5'd1, 5'd2, 5'd9);  cycle();
    applyStimulus(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle();
    checkOutput("prio_sel_a", ex_sel_a, 1);
    checkOutput("prio_sel_b", ex_sel_b, 1);

    // Hold during a load stall; the load itself forwards x9 from MEM
    load(5'd9, 5'd3);
    cycle();
    checkOutput("hold_load_sel_a", ex_sel_a, 2);
    alu(5'd3, 5'd4, 5'd14);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("hold_stall", stall_id, 1);
      cycle();
      checkOutput("hold_sel_a", ex_sel_a, 2);
      checkOutput("hold_sel_b", ex_sel_b, 0);
    end
    hold = 1'b0;
    #1 checkOutput("post_hold_stall", stall_id, 1);

    // Flush during the stall
    flush = 1'b1;
    #1 checkOutput("flush_stall", stall_id, 0);
    cycle();
    checkOutput("flush_sel_a", ex_sel_a, 0);
    checkOutput("flush_sel_b", ex_sel_b, 0);
    flush = 1'b0;

    // Old load now in MEM: forwarded, no stall
    load(5'd3, 5'd3);
    #1 checkOutput("ld_after_flush_stall", stall_id, 0);
    cycle();
    checkOutput("ld_after_flush_sel_a", ex_sel_a, 2);

    // Asynchronous reset mid-stall
    alu(5'd3, 5'd4, 5'd14);
    #1 checkOutput("pre_reset_stall", stall_id, 1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_stall", stall_id, 0);
    checkOutput("async_reset_sel_a", ex_sel_a, 0);
    checkOutput("async_reset_sel_b", ex_sel_b, 0);

    // Load-use with a 2-cycle penalty on the second instance
    target2 = 1'b1;
    nop();
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    load(5'd1, 5'd3);
    cycle();
    alu(5'd3, 5'd4, 5'd14);
    #1 checkOutput("lu2_stall_1", stall_id2, 1);
    checkOutput("lu2_other_inst_stall", stall_id, 0);
    cycle();
    checkOutput("lu2_bubble1_sel_a", ex_sel_a2, 0);
    #1 checkOutput("lu2_stall_2", stall_id2, 1);
    cycle();
    checkOutput("lu2_bubble2_sel_a", ex_sel_a2, 0);
    #1 checkOutput("lu2_stall_3", stall_id2, 0);
    cycle();
    checkOutput("lu2_sel_a", ex_sel_a2, 3);
    checkOutput("lu2_sel_b", ex_sel_b2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
